// File: rtl/wave_plotter.sv
// Waveform plotter: decimates audio samples into 320 min/max columns and streams
// erase/draw pixel writes to a 320x240 monochrome vga_adapter.
module wave_plotter #(
    parameter int DECIM  = 256,
    parameter int CENTER = 119
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    input  logic        pause,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic        vga_color,
    output logic        vga_plot,
    output logic        busy,
    output logic        overrun
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ERASE   = 3'd2,
        DRAW    = 3'd3,
        ADVANCE = 3'd4
    } state_t;

    localparam logic [15:0] DECIM_LAST = 16'(DECIM - 1);
    localparam logic [8:0]  X_LAST     = 9'd319;

    function automatic logic [7:0] map_row(input logic [15:0] s);
        logic signed [15:0] c;
        logic [15:0]        d;
        if ($signed(s) > 16'sd119) begin
            c = 16'sd119;
        end else if ($signed(s) < -16'sd120) begin
            c = -16'sd120;
        end else begin
            c = $signed(s);
        end
        d = 16'(CENTER) - $unsigned(c);
        return d[7:0];
    endfunction

    state_t         state_r, state_next_s;
    logic [15:0]    dec_cnt_r;
    logic           pending_r;
    logic [7:0]     pending_y_r, cur_y_r, y_prev_r;
    logic           first_r;
    logic [8:0]     x_r;
    logic [319:0]   valid_r;
    logic [15:0]    col_mem_r [0:319];
    logic [7:0]     old_min_r, old_max_r, new_min_r, new_max_r;
    logic [7:0]     vga_y_r;
    logic           vga_color_r, vga_plot_r, busy_r, overrun_r;

    logic           capture_s, consume_s;
    logic [15:0]    mem_word_s;
    logic [7:0]     prev_s, new_min_s, new_max_s;
    logic [7:0]     y_next_s;
    logic           color_next_s, plot_next_s;

    assign capture_s  = sample_valid && !pause && (dec_cnt_r == DECIM_LAST);
    assign consume_s  = (state_r == IDLE) && pending_r;
    assign mem_word_s = col_mem_r[x_r];

    // Segment endpoints; the first column (after reset or at x=0) has no predecessor.
    always_comb begin
        prev_s    = 8'd0;
        new_min_s = 8'd0;
        new_max_s = 8'd0;
        if ((x_r == 9'd0) || first_r) begin
            prev_s = cur_y_r;
        end else begin
            prev_s = y_prev_r;
        end
        if (cur_y_r < prev_s) begin
            new_min_s = cur_y_r;
            new_max_s = prev_s;
        end else begin
            new_min_s = prev_s;
            new_max_s = cur_y_r;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = pending_r ? LOAD : IDLE;
            LOAD:    state_next_s = valid_r[x_r] ? ERASE : DRAW;
            ERASE:   state_next_s = (vga_y_r == old_max_r) ? DRAW : ERASE;
            DRAW:    state_next_s = (vga_y_r == new_max_r) ? ADVANCE : DRAW;
            ADVANCE: state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Next pixel values; vga_y doubles as the scan counter within ERASE/DRAW.
    always_comb begin
        y_next_s     = vga_y_r;
        color_next_s = vga_color_r;
        plot_next_s  = 1'b0;
        case (state_r)
            LOAD: begin
                plot_next_s = 1'b1;
                if (valid_r[x_r]) begin
                    y_next_s     = mem_word_s[15:8];
                    color_next_s = 1'b0;
                end else begin
                    y_next_s     = new_min_s;
                    color_next_s = 1'b1;
                end
            end
            ERASE: begin
                plot_next_s = 1'b1;
                if (vga_y_r == old_max_r) begin
                    y_next_s     = new_min_r;
                    color_next_s = 1'b1;
                end else begin
                    y_next_s     = vga_y_r + 8'd1;
                    color_next_s = 1'b0;
                end
            end
            DRAW: begin
                color_next_s = 1'b1;
                if (vga_y_r == new_max_r) begin
                    plot_next_s = 1'b0;
                end else begin
                    plot_next_s = 1'b1;
                    y_next_s    = vga_y_r + 8'd1;
                end
            end
            default: begin
                plot_next_s = 1'b0;
            end
        endcase
    end

    // Registered pixel and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_y_r     <= 8'd0;
            vga_color_r <= 1'b0;
            vga_plot_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            vga_y_r     <= y_next_s;
            vga_color_r <= color_next_s;
            vga_plot_r  <= plot_next_s;
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Decimation, pending capture and column bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_cnt_r   <= 16'd0;
            pending_r   <= 1'b0;
            pending_y_r <= 8'd0;
            cur_y_r     <= 8'd0;
            y_prev_r    <= 8'd0;
            first_r     <= 1'b1;
            x_r         <= 9'd0;
            valid_r     <= {320{1'b0}};
            old_min_r   <= 8'd0;
            old_max_r   <= 8'd0;
            new_min_r   <= 8'd0;
            new_max_r   <= 8'd0;
            overrun_r   <= 1'b0;
        end else begin
            if (sample_valid && !pause) begin
                if (dec_cnt_r == DECIM_LAST) begin
                    dec_cnt_r <= 16'd0;
                end else begin
                    dec_cnt_r <= dec_cnt_r + 16'd1;
                end
            end
            // A capture on the consuming edge refills pending instead of clearing it.
            if (capture_s) begin
                pending_r   <= 1'b1;
                pending_y_r <= map_row(sample);
            end else if (consume_s) begin
                pending_r <= 1'b0;
            end
            overrun_r <= capture_s && pending_r && !consume_s;
            if (consume_s) begin
                cur_y_r <= pending_y_r;
            end
            if (state_r == LOAD) begin
                old_min_r <= mem_word_s[15:8];
                old_max_r <= mem_word_s[7:0];
                new_min_r <= new_min_s;
                new_max_r <= new_max_s;
            end
            if (state_r == ADVANCE) begin
                valid_r[x_r] <= 1'b1;
                y_prev_r     <= cur_y_r;
                first_r      <= 1'b0;
                x_r          <= (x_r == X_LAST) ? 9'd0 : x_r + 9'd1;
            end
        end
    end

    // Column memory; contents are qualified by valid_r so they are never reset.
    always_ff @(posedge clk) begin
        if (state_r == ADVANCE) begin
            col_mem_r[x_r] <= {new_min_r, new_max_r};
        end
    end

    assign vga_x     = x_r;
    assign vga_y     = vga_y_r;
    assign vga_color = vga_color_r;
    assign vga_plot  = vga_plot_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
endmodule

// File: tb/tb_wave_plotter.sv
// Directed bench for wave_plotter: a column model fills a pixel scoreboard that a
// negedge monitor drains; two instances cover DECIM=1 and DECIM=4.
module tb_wave_plotter;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sample1_s, sample4_s;
    logic        sample_valid1_s, sample_valid4_s, pause1_s, pause4_s;
    logic [8:0]  vga_x1_s, vga_x4_s;
    logic [7:0]  vga_y1_s, vga_y4_s;
    logic        vga_color1_s, vga_color4_s, vga_plot1_s, vga_plot4_s;
    logic        busy1_s, busy4_s, overrun1_s, overrun4_s;

    int total = 0;
    int passed = 0;
    logic [17:0] q1[$];
    logic [17:0] q4[$];
    logic [17:0] e1, e4;
    int pix_cnt1 = 0, erase_cnt1 = 0, busy_cnt1 = 0, ovr_cnt1 = 0, pix_cnt4 = 0;

    int m_x, m_prev;
    bit m_first;
    bit m_valid [320];
    int m_min [320];
    int m_max [320];

    logic [15:0] s4_tab [8] = '{16'd10, 16'd20, 16'd30, 16'd40,
                                16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8};

    always #5 clk = ~clk;

    wave_plotter #(.DECIM(1)) u_dut1 (
        .clk(clk), .reset(reset), .sample(sample1_s), .sample_valid(sample_valid1_s),
        .pause(pause1_s), .vga_x(vga_x1_s), .vga_y(vga_y1_s), .vga_color(vga_color1_s),
        .vga_plot(vga_plot1_s), .busy(busy1_s), .overrun(overrun1_s)
    );

    wave_plotter #(.DECIM(4)) u_dut4 (
        .clk(clk), .reset(reset), .sample(sample4_s), .sample_valid(sample_valid4_s),
        .pause(pause4_s), .vga_x(vga_x4_s), .vga_y(vga_y4_s), .vga_color(vga_color4_s),
        .vga_plot(vga_plot4_s), .busy(busy4_s), .overrun(overrun4_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int map_y(input logic [15:0] s);
        int v;
        v = int'($signed(s));
        if (v > 119) v = 119;
        if (v < -120) v = -120;
        return 119 - v;
    endfunction

    task automatic model_reset();
        m_x = 0;
        m_prev = 0;
        m_first = 1'b1;
        for (int i = 0; i < 320; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_column(input int y);
        int p, lo, hi;
        p  = (m_x == 0 || m_first) ? y : m_prev;
        lo = (y < p) ? y : p;
        hi = (y < p) ? p : y;
        if (m_valid[m_x]) begin
            for (int r = m_min[m_x]; r <= m_max[m_x]; r++) q1.push_back({9'(m_x), 8'(r), 1'b0});
        end
        for (int r = lo; r <= hi; r++) q1.push_back({9'(m_x), 8'(r), 1'b1});
        m_min[m_x] = lo;
        m_max[m_x] = hi;
        m_valid[m_x] = 1'b1;
        m_prev = y;
        m_first = 1'b0;
        m_x = (m_x == 319) ? 0 : m_x + 1;
    endtask

    task automatic strobe1(input logic [15:0] s);
        @(negedge clk);
        sample1_s = s;
        sample_valid1_s = 1'b1;
        @(negedge clk);
        sample_valid1_s = 1'b0;
    endtask

    task automatic wait_idle1();
        int quiet, n;
        quiet = 0;
        n = 0;
        while (quiet < 3 && n < 3000) begin
            @(negedge clk);
            n++;
            if (busy1_s) quiet = 0;
            else quiet++;
        end
        check("idle1_in_time", 32'(n < 3000), 32'd1);
    endtask

    // Pixel scoreboard and event counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (vga_plot1_s) begin
            pix_cnt1++;
            if (!vga_color1_s) erase_cnt1++;
            check("px1_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                check("px1_xyc", 32'({vga_x1_s, vga_y1_s, vga_color1_s}), 32'(e1));
            end
        end
        if (busy1_s) busy_cnt1++;
        if (overrun1_s) ovr_cnt1++;
        if (vga_plot4_s) begin
            pix_cnt4++;
            check("px4_expected", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                check("px4_xyc", 32'({vga_x4_s, vga_y4_s, vga_color4_s}), 32'(e4));
            end
        end
    end

    initial begin
        int n, pc, e0;
        reset = 1'b1;
        sample1_s = 16'd0; sample_valid1_s = 1'b0; pause1_s = 1'b0;
        sample4_s = 16'd0; sample_valid4_s = 1'b0; pause4_s = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_plot", 32'(vga_plot1_s), 32'd0);
        check("rst_busy", 32'(busy1_s), 32'd0);
        check("rst_x", 32'(vga_x1_s), 32'd0);
        check("rst_y", 32'(vga_y1_s), 32'd0);
        check("rst_color", 32'(vga_color1_s), 32'd0);
        check("rst_overrun", 32'(overrun1_s), 32'd0);
        reset = 1'b0;
        model_reset();

        // DECIM=4: only every 4th strobe becomes a column.
        q4.push_back({9'd0, 8'd79, 1'b1});
        for (int r = 79; r <= 127; r++) q4.push_back({9'd1, 8'(r), 1'b1});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sample4_s = s4_tab[i];
            sample_valid4_s = 1'b1;
            @(negedge clk);
            sample_valid4_s = 1'b0;
            repeat (8) @(negedge clk);
        end
        n = 0;
        while ((q4.size() != 0 || busy4_s) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("d4_done_in_time", 32'(n < 500), 32'd1);
        check("d4_pixels", 32'(pix_cnt4), 32'd50);
        check("d4_x", 32'(vga_x4_s), 32'd2);

        // Single-pixel column and first-pixel latency.
        busy_cnt1 = 0;
        model_column(map_y(16'd0));
        strobe1(16'd0);
        check("lat_e0_plot", 32'(vga_plot1_s), 32'd0);
        check("lat_e0_busy", 32'(busy1_s), 32'd0);
        @(negedge clk);
        check("lat_load_plot", 32'(vga_plot1_s), 32'd0);
        check("lat_load_busy", 32'(busy1_s), 32'd1);
        @(negedge clk);
        check("lat_draw_plot", 32'(vga_plot1_s), 32'd1);
        check("lat_draw_y", 32'(vga_y1_s), 32'd119);
        check("lat_draw_x", 32'(vga_x1_s), 32'd0);
        check("lat_draw_color", 32'(vga_color1_s), 32'd1);
        @(negedge clk);
        check("adv_plot", 32'(vga_plot1_s), 32'd0);
        @(negedge clk);
        check("adv_x", 32'(vga_x1_s), 32'd1);
        repeat (2) @(negedge clk);
        check("busy_cycles", 32'(busy_cnt1), 32'd3);

        // Clamp extremes.
        model_column(map_y(16'h7FFF));
        strobe1(16'h7FFF);
        wait_idle1();
        model_column(map_y(16'h8000));
        strobe1(16'h8000);
        wait_idle1();
        check("clamp_x", 32'(vga_x1_s), 32'd3);

        // Overrun: three back-to-back captures, the middle one is lost.
        model_column(map_y(16'd119));
        strobe1(16'd119);
        wait_idle1();
        ovr_cnt1 = 0;
        model_column(map_y(16'hFF88));
        model_column(map_y(16'hFF9C));
        @(negedge clk);
        sample1_s = 16'hFF88; sample_valid1_s = 1'b1;
        @(negedge clk);
        sample1_s = 16'd50;
        @(negedge clk);
        sample1_s = 16'hFF9C;
        @(negedge clk);
        sample_valid1_s = 1'b0;
        wait_idle1();
        check("overrun_pulses", 32'(ovr_cnt1), 32'd1);
        check("overrun_x", 32'(vga_x1_s), 32'd6);

        // Full wrap of 320 columns and revisit of column 0.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q1.delete();
        model_reset();
        e0 = erase_cnt1;
        for (int i = 0; i < 321; i++) begin
            model_column(map_y(16'd0));
            strobe1(16'd0);
            repeat (8) @(negedge clk);
            if (i == 319) check("wrap_x0", 32'(vga_x1_s), 32'd0);
        end
        check("wrap_erase_pixels", 32'(erase_cnt1 - e0), 32'd1);
        check("wrap_x1", 32'(vga_x1_s), 32'd1);

        // Reset mid-DRAW, then paused strobes are ignored.
        model_column(map_y(16'd119));
        strobe1(16'd119);
        repeat (20) @(negedge clk);
        check("mid_draw_active", 32'(vga_plot1_s), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_plot", 32'(vga_plot1_s), 32'd0);
        check("mid_rst_busy", 32'(busy1_s), 32'd0);
        check("mid_rst_x", 32'(vga_x1_s), 32'd0);
        q1.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        pause1_s = 1'b1;
        busy_cnt1 = 0;
        pc = pix_cnt1;
        for (int i = 0; i < 5; i++) strobe1(16'd33);
        repeat (10) @(negedge clk);
        check("pause_busy", 32'(busy_cnt1), 32'd0);
        check("pause_pixels", 32'(pix_cnt1 - pc), 32'd0);
        pause1_s = 1'b0;
        e0 = erase_cnt1;
        model_column(map_y(16'hFFCE));
        strobe1(16'hFFCE);
        wait_idle1();
        check("post_rst_no_erase", 32'(erase_cnt1 - e0), 32'd0);
        check("post_rst_x", 32'(vga_x1_s), 32'd1);

        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
